// File: rtl/uart_reg_responder.sv
// Transmit-only 16550-style register target: register map, 16x baud generator
// and a single-holding-register serial transmitter.
module uart_reg_responder #(
    parameter logic [15:0] DIV_RESET     = 16'h0001,
    parameter int unsigned TICKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       cs_i,
    input  logic       wr_i,
    input  logic       rd_i,
    input  logic [2:0] a_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    output logic       int_o,
    output logic       sout_o
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;

    localparam int unsigned TW    = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TICKS_PER_BIT - 1);

    state_e        state_q, state_d;
    logic [7:0]    lcr_q, lcr_d, scr_q, scr_d, thr_q, thr_d, dout_q, dout_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    ier_q, ier_d;
    logic [4:0]    mcr_q, mcr_d;
    logic [15:0]   div_q, div_d, bcnt_q, bcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [1:0]    flen_q, flen_d;
    logic          fpen_q, fpen_d, fstb_q, fstb_d, par_q, par_d;
    logic          fen_q, fen_d, thr_full_q, thr_full_d, thre_pend_q, thre_pend_d;
    logic          int_q, int_d;

    logic       wr_en, rd_en, dlab, tick, bit_end, load, thre_int;
    logic [7:0] iir, lsr, rdata;

    always_comb begin
        wr_en    = cs_i & wr_i;
        rd_en    = cs_i & rd_i & ~wr_i;
        dlab     = lcr_q[7];
        tick     = (div_q != 16'd0) && (bcnt_q == div_q - 16'd1);
        bit_end  = tick && (tcnt_q == TLAST);
        thre_int = ier_q[1] & thre_pend_q;
        iir      = {fen_q, fen_q, 2'b00, thre_int ? 4'b0010 : 4'b0001};
        lsr      = {1'b0, ~thr_full_q & (state_q == IDLE), ~thr_full_q, 5'b00000};
        case (a_i)
            3'd0:    rdata = dlab ? div_q[7:0] : 8'h00;
            3'd1:    rdata = dlab ? div_q[15:8] : {4'h0, ier_q};
            3'd2:    rdata = iir;
            3'd3:    rdata = lcr_q;
            3'd4:    rdata = {3'b000, mcr_q};
            3'd5:    rdata = lsr;
            3'd6:    rdata = 8'h00;
            default: rdata = scr_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        lcr_d       = lcr_q;
        scr_d       = scr_q;
        thr_d       = thr_q;
        dout_d      = dout_q;
        shift_d     = shift_q;
        ier_d       = ier_q;
        mcr_d       = mcr_q;
        div_d       = div_q;
        bcnt_d      = (div_q == 16'd0 || tick) ? '0 : bcnt_q + 16'd1;
        tcnt_d      = tcnt_q;
        bitcnt_d    = bitcnt_q;
        flen_d      = flen_q;
        fpen_d      = fpen_q;
        fstb_d      = fstb_q;
        par_d       = par_q;
        fen_d       = fen_q;
        thr_full_d  = thr_full_q;
        thre_pend_d = thre_pend_q;
        load        = 1'b0;

        if (rd_en) begin
            dout_d = rdata;
            if (a_i == 3'd2 && thre_int) thre_pend_d = 1'b0;
        end

        if (state_q != IDLE && tick) tcnt_d = bit_end ? '0 : tcnt_q + 1'b1;
        case (state_q)
            IDLE:    load = thr_full_q;
            START:   if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    shift_d  = shift_q >> 1;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd4 + {1'b0, flen_q}) state_d = fpen_q ? PARITY : STOP1;
                end
            end
            PARITY:  if (bit_end) state_d = STOP1;
            STOP1: begin
                if (bit_end) begin
                    if (fstb_q)          state_d = STOP2;
                    else if (thr_full_q) load = 1'b1;
                    else                 state_d = IDLE;
                end
            end
            STOP2: begin
                if (bit_end) begin
                    if (thr_full_q) load = 1'b1;
                    else            state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame format is captured here so later LCR writes cannot disturb it.
        if (load) begin
            state_d     = START;
            shift_d     = thr_q;
            tcnt_d      = '0;
            bitcnt_d    = '0;
            flen_d      = lcr_q[1:0];
            fpen_d      = lcr_q[3];
            fstb_d      = lcr_q[2];
            par_d       = (^(thr_q & (8'hFF >> (2'd3 - lcr_q[1:0])))) ^ ~lcr_q[4];
            thr_full_d  = 1'b0;
            thre_pend_d = 1'b1;
        end

        // Bus writes come last so a THR write beats a same-edge shifter load.
        if (wr_en) begin
            case (a_i)
                3'd0: begin
                    if (dlab) begin
                        div_d[7:0] = din_i;
                        bcnt_d     = '0;
                    end else begin
                        thr_d       = din_i;
                        thr_full_d  = 1'b1;
                        thre_pend_d = 1'b0;
                    end
                end
                3'd1: begin
                    if (dlab) begin
                        div_d[15:8] = din_i;
                        bcnt_d      = '0;
                    end else begin
                        ier_d = din_i[3:0];
                        if (din_i[1] && !ier_q[1] && !thr_full_q) thre_pend_d = 1'b1;
                    end
                end
                3'd2: begin
                    fen_d = din_i[0];
                    if (din_i[2]) thr_full_d = 1'b0;
                end
                3'd3:    lcr_d = din_i;
                3'd4:    mcr_d = din_i[4:0];
                3'd7:    scr_d = din_i;
                default: ;
            endcase
        end

        int_d = ier_d[1] & thre_pend_d;
    end

    always_comb begin
        case (state_q)
            START:   sout_o = 1'b0;
            DATA:    sout_o = shift_q[0];
            PARITY:  sout_o = par_q;
            default: sout_o = 1'b1;
        endcase
        if (lcr_q[6])      sout_o = 1'b0;
        else if (mcr_q[4]) sout_o = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            lcr_q       <= '0;
            scr_q       <= '0;
            thr_q       <= '0;
            dout_q      <= '0;
            shift_q     <= '0;
            ier_q       <= '0;
            mcr_q       <= '0;
            div_q       <= DIV_RESET;
            bcnt_q      <= '0;
            tcnt_q      <= '0;
            bitcnt_q    <= '0;
            flen_q      <= '0;
            fpen_q      <= 1'b0;
            fstb_q      <= 1'b0;
            par_q       <= 1'b0;
            fen_q       <= 1'b0;
            thr_full_q  <= 1'b0;
            thre_pend_q <= 1'b0;
            int_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lcr_q       <= lcr_d;
            scr_q       <= scr_d;
            thr_q       <= thr_d;
            dout_q      <= dout_d;
            shift_q     <= shift_d;
            ier_q       <= ier_d;
            mcr_q       <= mcr_d;
            div_q       <= div_d;
            bcnt_q      <= bcnt_d;
            tcnt_q      <= tcnt_d;
            bitcnt_q    <= bitcnt_d;
            flen_q      <= flen_d;
            fpen_q      <= fpen_d;
            fstb_q      <= fstb_d;
            par_q       <= par_d;
            fen_q       <= fen_d;
            thr_full_q  <= thr_full_d;
            thre_pend_q <= thre_pend_d;
            int_q       <= int_d;
        end
    end

    assign dout_o = dout_q;
    assign int_o  = int_q;
endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed plus randomized bench for uart_reg_responder; serial frames are
// predicted from the line-format rules and compared at bit centres.
module tb_uart_reg_responder;
    logic       clk = 1'b0, rstn = 1'b0, cs = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [2:0] a = '0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       irq, sout;

    int unsigned n_checks = 0, n_err = 0;
    logic       rec_sout [0:1023];
    logic [7:0] rec_lsr  [0:1023];

    always #5 clk = ~clk;

    uart_reg_responder #(.DIV_RESET(16'h0001), .TICKS_PER_BIT(16)) dut (
        .clk_i(clk), .rstn_i(rstn), .cs_i(cs), .wr_i(wr), .rd_i(rd),
        .a_i(a), .din_i(din), .dout_o(dout), .int_o(irq), .sout_o(sout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk); cs = 1'b1; wr = 1'b1; rd = 1'b0; a = addr; din = data;
        @(negedge clk); cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] addr, output logic [7:0] data);
        @(negedge clk); cs = 1'b1; rd = 1'b1; wr = 1'b0; a = addr;
        @(negedge clk); cs = 1'b0; rd = 1'b0; data = dout;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        bus_rd(addr, d);
        chk(tag, d, exp);
    endtask

    task automatic set_div(input logic [15:0] dv);
        bus_wr(3'd3, 8'h80);
        bus_wr(3'd0, dv[7:0]);
        bus_wr(3'd1, dv[15:8]);
        bus_wr(3'd3, 8'h00);
    endtask

    // Line image of one frame: bit k is the level during bit-time k.
    function automatic void model_frame(input logic [7:0] data, input logic [7:0] lcr,
                                        output logic [31:0] bits, output int unsigned nb);
        int unsigned nd;
        logic p;
        nd = 5 + int'(lcr[1:0]);
        p = 1'b0;
        bits = '0;
        for (int unsigned i = 0; i < nd; i++) begin
            bits[1 + i] = data[i];
            p = p ^ data[i];
        end
        nb = 1 + nd;
        if (lcr[3]) begin
            bits[nb] = lcr[4] ? p : ~p;
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        if (lcr[2]) begin
            bits[nb] = 1'b1;
            nb++;
        end
    endfunction

    // Holds an LSR read every clock, optionally replacing one cycle with a THR write.
    task automatic record(input int unsigned n, input int unsigned wr_at, input logic [7:0] wd);
        for (int unsigned i = 0; i < n; i++) begin
            cs = 1'b1; rd = 1'b1; wr = (i == wr_at);
            a = (i == wr_at) ? 3'd0 : 3'd5; din = wd;
            @(negedge clk);
            rec_sout[i] = sout;
            rec_lsr[i]  = dout;
        end
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    function automatic int unsigned first_temt(input int unsigned n);
        for (int unsigned i = 2; i < n; i++) if (rec_lsr[i][6]) return i;
        return n + 1000;
    endfunction

    task automatic check_stream(input string tag, input logic [31:0] expv,
                                input int unsigned nb, input int unsigned per);
        logic [31:0] got;
        got = '0;
        for (int unsigned k = 0; k < nb; k++) got[k] = rec_sout[per / 2 + k * per];
        chk(tag, got, expv);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] data,
                              input logic [7:0] lcr_v, input int unsigned dv);
        logic [31:0] ev;
        int unsigned nb, per, n, t;
        model_frame(data, lcr_v, ev, nb);
        per = 16 * dv;
        n   = per * nb + 24;
        bus_wr(3'd3, lcr_v);
        bus_wr(3'd0, data);
        record(n, 9999, 8'h00);
        chk({tag, "/lsr_full"}, rec_lsr[0], 8'h00);
        chk({tag, "/lsr_load"}, rec_lsr[1], 8'h20);
        check_stream({tag, "/bits"}, ev, nb, per);
        t = first_temt(n);
        chk({tag, "/len"}, {31'd0, (t + dv + 2 >= per * nb) && (t <= per * nb + 2)}, 32'd1);
        chk({tag, "/lsr_end"}, rec_lsr[n - 1], 8'h60);
    endtask

    task automatic wait_idle(input string tag);
        logic [7:0] d;
        d = '0;
        for (int unsigned i = 0; i < 2000; i++) begin
            bus_rd(3'd5, d);
            if (d == 8'h60) break;
        end
        chk(tag, d, 8'h60);
    endtask

    initial begin
        logic [31:0] e1, e2;
        int unsigned nb1, nb2;
        logic [7:0] rl, rdat;

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst/dout", dout, 8'h00);
        chk("rst/sout", sout, 1'b1);
        chk("rst/int", irq, 1'b0);
        rd_chk("rst/lsr", 3'd5, 8'h60);
        rd_chk("rst/iir", 3'd2, 8'h01);
        rd_chk("rst/lcr", 3'd3, 8'h00);

        bus_wr(3'd3, 8'h83);
        bus_wr(3'd0, 8'h02);
        bus_wr(3'd1, 8'h00);
        bus_wr(3'd3, 8'h03);
        rd_chk("f55/lsr_pre", 3'd5, 8'h60);
        send_frame("f55", 8'h55, 8'h03, 2);

        send_frame("parE", 8'h07, 8'h1B, 2);
        chk("parE/bit", rec_sout[16 + 9 * 32], 1'b1);
        send_frame("parO", 8'h07, 8'h0B, 2);
        chk("parO/bit", rec_sout[16 + 9 * 32], 1'b0);

        set_div(16'd1);
        model_frame(8'hFF, 8'h04, e1, nb1);
        bus_wr(3'd3, 8'h04);
        bus_wr(3'd0, 8'hFF);
        record(16 * 2 * nb1 + 24, 20, 8'hFF);
        check_stream("b2b/bits", e1 | (e1 << nb1), 2 * nb1, 16);
        chk("b2b/len", {31'd0, first_temt(16 * 2 * nb1 + 24) inside {[2 * 16 * nb1 - 1 : 2 * 16 * nb1 + 2]}}, 32'd1);

        for (int unsigned it = 0; it < 8; it++) begin
            int unsigned dv;
            dv = $urandom_range(1, 2);
            rl = 8'($urandom) & 8'h3F;
            rdat = 8'($urandom);
            set_div(16'(dv));
            send_frame($sformatf("rnd%0d_l%02h_d%02h", it, rl, rdat), rdat, rl, dv);
        end

        bus_wr(3'd1, 8'hF2);
        chk("int/ier_set", irq, 1'b1);
        bus_wr(3'd0, 8'hA5);
        chk("int/thr_wr", irq, 1'b0);
        @(negedge clk);
        chk("int/load", irq, 1'b1);
        rd_chk("int/iir1", 3'd2, 8'h02);
        chk("int/cleared", irq, 1'b0);
        rd_chk("int/iir2", 3'd2, 8'h01);
        wait_idle("int/idle");
        rd_chk("int/ier_rd", 3'd1, 8'h02);

        bus_wr(3'd3, 8'h80);
        bus_wr(3'd0, 8'h11);
        bus_wr(3'd1, 8'h22);
        rd_chk("dlab/dll", 3'd0, 8'h11);
        rd_chk("dlab/dlm", 3'd1, 8'h22);
        rd_chk("dlab/lcr", 3'd3, 8'h80);
        bus_wr(3'd3, 8'h00);
        rd_chk("dlab/ier", 3'd1, 8'h02);
        rd_chk("misc/rbr", 3'd0, 8'h00);
        rd_chk("misc/msr", 3'd6, 8'h00);
        bus_wr(3'd7, 8'hA7);
        rd_chk("misc/scr", 3'd7, 8'hA7);
        bus_wr(3'd4, 8'hFF);
        rd_chk("misc/mcr", 3'd4, 8'h1F);
        bus_wr(3'd5, 8'h00);
        rd_chk("misc/lsr_ro", 3'd5, 8'h60);
        bus_wr(3'd3, 8'h40);
        chk("force/break", sout, 1'b0);
        bus_wr(3'd3, 8'h00);
        chk("force/loop", sout, 1'b1);
        bus_wr(3'd4, 8'h00);

        set_div(16'd1);
        bus_wr(3'd3, 8'h03);
        bus_wr(3'd0, 8'h00);
        bus_wr(3'd0, 8'h3C);
        rd_chk("fcr/lsr_full", 3'd5, 8'h00);
        bus_wr(3'd2, 8'h05);
        rd_chk("fcr/lsr_clr", 3'd5, 8'h20);
        rd_chk("fcr/iir", 3'd2, 8'hC1);
        repeat (30) @(negedge clk);
        chk("mid/sout", sout, 1'b0);
        #3 rstn = 1'b0;
        #1;
        chk("arst/sout", sout, 1'b1);
        chk("arst/int", irq, 1'b0);
        chk("arst/dout", dout, 8'h00);
        @(negedge clk);
        rstn = 1'b1;
        rd_chk("arst/lsr", 3'd5, 8'h60);
        rd_chk("arst/iir", 3'd2, 8'h01);
        rd_chk("arst/lcr", 3'd3, 8'h00);
        rd_chk("arst/ier", 3'd1, 8'h00);
        rd_chk("arst/mcr", 3'd4, 8'h00);
        rd_chk("arst/scr", 3'd7, 8'h00);
        bus_wr(3'd3, 8'h80);
        rd_chk("arst/dll", 3'd0, 8'h01);
        rd_chk("arst/dlm", 3'd1, 8'h00);
        bus_wr(3'd3, 8'h00);
        chk("arst/sout_idle", sout, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_reg_responder.md
Name: uart_reg_responder

Overview:
- Register-bus target for the UART configuration initiator.
- Accepts cs/wr/rd/a/din cycles and implements a 16550-compatible register map: LCR, DLL/DLM with DLAB, IER, FCR/IIR, MCR, LSR, SCR, THR.
- Drives a serial TX line through a single holding register, a shift register and a 16x baud generator.
- Acts as a lightweight, transmit-only stand-in for the full UART core, for bring-up and for closed-loop tests of the config FSM.

Parameters:
- DIV_RESET, 16'h0001, divisor value loaded at reset (clocks per 16x tick).
- TICKS_PER_BIT, 16, 16x ticks per serial bit.

Ports:
- clk  in  1  single clock domain; all state updates on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- cs  in  1  chip select.
- wr  in  1  write strobe; level, one write per clk with cs&wr.
- rd  in  1  read strobe; level.
- a  in  3  register address.
- din  in  8  write data.
- dout  out  8  registered read data.
- int  out  1  interrupt request, active high.
- sout  out  1  serial data, idle high.

Behaviour:
- Reset (async, immediate, mid-frame included):
  - LCR, IER, MCR, SCR, FCR enable, thr_full, thre_pend, dout all 0.
  - divisor = DIV_RESET; sout = 1; int = 0; FSM = IDLE.
- Bus write: takes effect on the clk edge where cs&wr=1.
- Bus read: when cs&rd=1 and wr=0, dout loads the addressed value next edge (latency 1). Otherwise dout holds. cs&wr&rd: write wins, dout holds.
- Register map, DLAB = LCR[7]:
  - a=0: DLAB=0 write THR (sets thr_full, clears thre_pend), read RBR = 0x00. DLAB=1 DLL R/W.
  - a=1: DLAB=0 IER, bits[3:0] R/W, upper bits read 0. DLAB=1 DLM R/W.
  - a=2 write FCR: bit0 stored as fen; bit2=1 clears thr_full. Not readable.
  - a=2 read IIR: {fen,fen,2'b00, thre_int ? 4'b0010 : 4'b0001}. A read returning id 0010 clears thre_pend.
  - a=3: LCR, 8-bit R/W.
  - a=4: MCR, bits[4:0] R/W.
  - a=5: LSR, read-only: bit5 THRE = ~thr_full, bit6 TEMT = ~thr_full & FSM==IDLE, others 0. Writes ignored.
  - a=6: MSR reads 0x00.
  - a=7: SCR, 8-bit R/W.
- Baud generator:
  - 16-bit counter emits a 1-clk tick every divisor clocks.
  - Counter restarts at 0 on any DLL/DLM write.
  - divisor = 0: no ticks; the FSM freezes in place.
- TX FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - Each non-IDLE state lasts TICKS_PER_BIT ticks.
  - IDLE with thr_full: next edge loads shifter from THR, clears thr_full, sets thre_pend, goes to START, resets tick counter.
  - START: sout=0.
  - DATA: LSB first, 5+LCR[1:0] bits.
  - PARITY: only if LCR[3]. Value is XOR of the transmitted data bits when LCR[4]=1 (even), its complement when LCR[4]=0. LCR[5] is ignored.
  - STOP1, then STOP2 if LCR[2]; sout=1.
  - After the last stop: START directly if thr_full, else IDLE.
  - LCR is sampled at the shifter load; later LCR writes do not affect the frame in flight.
- Boundary cases:
  - THR write while thr_full: overwrites; old byte lost.
  - THR write on the same edge as a shifter load: shifter takes the old byte, THR holds the new byte, thr_full stays 1.
  - FCR clear while a frame is in flight: the frame completes.
- Output forcing: sout forced 0 while LCR[6] (break); forced 1 while MCR[4] (loop). Break has priority.
- Interrupt: int = IER[1] & thre_pend, registered. A 0->1 write of IER[1] while THRE sets thre_pend. IER[0] is stored with no effect.

Test Plan:
- Reset, then read a=5, a=2, a=3 -> dout 0x60, 0x01, 0x00 one clk after each; sout=1; int=0.
- Write LCR=0x83, DLL=0x02, DLM=0x00, LCR=0x03, THR=0x55 -> start bit; bits 1,0,1,0,1,0,1,0; stop; 32 clk/bit, 320 clk total. LSR goes 0x60 -> 0x00 -> 0x20 (load) -> 0x60 at frame end.
- Parity: LCR=0x1B, THR=0x07 -> parity bit 1. LCR=0x0B, THR=0x07 -> parity bit 0. Frame length 11 bits in both cases.
- LCR=0x04, THR=0xFF -> 5 data ones + 2 stop bits; 8 bit-times total. Second THR write during the frame -> back-to-back frame with no idle bit.
- IER=0x02, THR=0xA5 -> int=1 after the shifter load. Read IIR -> 0x02 and int=0. Next IIR read -> 0x01.
- DLAB readback: DLL=0x11, DLM=0x22 read back exact, IER unchanged. rstn low mid-DATA -> sout=1 immediately; all registers back to reset values.
